// File: rtl/ddr_rd_burst_scheduler.sv
// ddr_rd_burst_scheduler
// Issues DDR read bursts that refill the playback read FIFO. It keeps a
// count of bursts committed to the DDR ring but not yet read
// (avail_bursts) and a count of bursts issued but not yet completed
// (outstanding). It then hands out one burst address per AXI AR handshake
// and wraps the address around the ring. The outstanding cap leaves
// headroom for refill requests that are still in synchronizer latency.
//
// Ports
//   clk, rst_n        DDR/AXI clock, async active-low reset
//   ctrl_rd_en        playback enable (synchronized)
//   ddr_rd_req        level refill request from FIFO prog_empty (synchronized)
//   clr               pulse: clear pointer, counters, errors (deferred while busy)
//   wr_burst_done     pulse: write path committed one burst
//   rd_cmd_valid/ready/addr  burst command handshake toward the AXI AR channel
//   rd_burst_done     pulse: RLAST of a burst accepted
//   avail_bursts      bursts in DDR not yet issued
//   outstanding       bursts issued, not yet completed
//   busy              not IDLE or reads still in flight
//   err               sticky: [0] avail overflow, [1] spurious rd_burst_done
module ddr_rd_burst_scheduler #(
    parameter int              ADDR_W          = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
    parameter int              BURST_BYTES     = 4096,
    parameter int              REGION_BURSTS   = 1024,
    parameter int              MAX_OUTSTANDING = 2,
    parameter int              CNT_W           = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_rd_en,
    input  logic              ddr_rd_req,
    input  logic              clr,
    input  logic              wr_burst_done,
    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic [ADDR_W-1:0] rd_cmd_addr,
    input  logic              rd_burst_done,
    output logic [CNT_W-1:0]  avail_bursts,
    output logic [2:0]        outstanding,
    output logic              busy,
    output logic [1:0]        err
);

    localparam int SLOT_W = $clog2(REGION_BURSTS);
    localparam int OFF_W  = $clog2(BURST_BYTES);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   avail_q, avail_d;
    logic [2:0]         out_q, out_d;
    logic [1:0]         err_q, err_d;
    logic               clr_pend_q, clr_pend_d;

    logic hs, clr_exec, start;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        addr_d     = addr_q;
        avail_d    = avail_q;
        out_d      = out_q;
        err_d      = err_q;
        clr_pend_d = clr_pend_q;

        hs       = (state_q == ISSUE) && rd_cmd_ready;
        // A clear only runs when nothing is in flight, so the pointer never
        // moves under a burst the AXI side still owns.
        clr_exec = (clr || clr_pend_q) && (state_q == IDLE) && (out_q == 3'd0);
        start    = (state_q == IDLE) && ctrl_rd_en && ddr_rd_req &&
                   (avail_q != '0) && (out_q < 3'(MAX_OUTSTANDING)) &&
                   !clr && !clr_pend_q;

        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (hs)    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Power-of-two ring: the natural wrap of slot_q gives REGION_BURSTS-1 -> 0.
        if (hs) begin
            slot_d = slot_q + 1'b1;
            addr_d = BASE_ADDR + (ADDR_W'(slot_d) << OFF_W);
        end

        case ({wr_burst_done, hs})
            2'b10: begin
                if (avail_q == CNT_W'(REGION_BURSTS)) err_d[0] = 1'b1;
                else                                  avail_d  = avail_q + CNT_W'(1);
            end
            2'b01:   avail_d = avail_q - CNT_W'(1);
            default: ;
        endcase

        case ({hs, rd_burst_done})
            2'b10: out_d = out_q + 3'd1;
            2'b01: begin
                if (out_q == 3'd0) err_d[1] = 1'b1;
                else               out_d    = out_q - 3'd1;
            end
            default: ;
        endcase

        // The clear overrides everything in its cycle, including a
        // coincident wr_burst_done.
        if (clr_exec) begin
            slot_d     = '0;
            addr_d     = BASE_ADDR;
            avail_d    = '0;
            err_d      = '0;
            clr_pend_d = 1'b0;
        end else if (clr) begin
            clr_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            addr_q     <= BASE_ADDR;
            avail_q    <= '0;
            out_q      <= '0;
            err_q      <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            addr_q     <= addr_d;
            avail_q    <= avail_d;
            out_q      <= out_d;
            err_q      <= err_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign rd_cmd_valid = (state_q == ISSUE);
    assign rd_cmd_addr  = addr_q;
    assign avail_bursts = avail_q;
    assign outstanding  = out_q;
    assign busy         = (state_q != IDLE) || (out_q != 3'd0);
    assign err          = err_q;

endmodule

// File: tb/tb_ddr_rd_burst_scheduler.sv
module tb_ddr_rd_burst_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_rd_en, ddr_rd_req, clr, wr_burst_done;
    logic        rd_cmd_valid, rd_cmd_ready, rd_burst_done;
    logic [31:0] rd_cmd_addr;
    logic [10:0] avail_bursts;
    logic [2:0]  outstanding;
    logic        busy;
    logic [1:0]  err;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ddr_rd_burst_scheduler dut (
        .clk(clk), .rst_n(rst_n), .ctrl_rd_en(ctrl_rd_en), .ddr_rd_req(ddr_rd_req),
        .clr(clr), .wr_burst_done(wr_burst_done), .rd_cmd_valid(rd_cmd_valid),
        .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
        .rd_burst_done(rd_burst_done), .avail_bursts(avail_bursts),
        .outstanding(outstanding), .busy(busy), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_n(input int n);
        for (int i = 0; i < n; i++) begin
            wr_burst_done = 1'b1;
            tick();
        end
        wr_burst_done = 1'b0;
    endtask

    task automatic pulse_rd();
        rd_burst_done = 1'b1;
        tick();
        rd_burst_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ctrl_rd_en = 0; ddr_rd_req = 0; clr = 0; wr_burst_done = 0;
        rd_cmd_ready = 0; rd_burst_done = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Runs playback with ready high, answering every handshake with
    // rd_burst_done one cycle later, until the ring is drained.
    task automatic run_drain(input int bound);
        logic hs;
        bit   done = 0;
        rd_cmd_ready = 1'b1;
        ctrl_rd_en   = 1'b1;
        ddr_rd_req   = 1'b1;
        for (int n = 0; n < bound && !done; n++) begin
            hs = rd_cmd_valid && rd_cmd_ready;
            tick();
            rd_burst_done = hs;
            if (avail_bursts == 0 && outstanding == 0 && !busy && !rd_burst_done) done = 1;
        end
        rd_burst_done = 1'b0;
        ctrl_rd_en    = 1'b0;
        rd_cmd_ready  = 1'b0;
        chk("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    // Scoreboard monitor: pops an expected address on every handshake and
    // checks AXI stability while a command is stalled.
    initial begin
        logic        stalled = 1'b0;
        logic [31:0] held    = '0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", {31'd0, rd_cmd_valid}, 32'd1);
                    chk("stall_addr", rd_cmd_addr, held);
                end
                if (rd_cmd_valid && rd_cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_cmd: got addr 0x%0h expected no command", rd_cmd_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("cmd_addr", rd_cmd_addr, e);
                    end
                end
                stalled = rd_cmd_valid && !rd_cmd_ready;
                held    = rd_cmd_addr;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values, sampled while reset is held.
        rst_n = 1'b0;
        ctrl_rd_en = 0; ddr_rd_req = 0; clr = 0; wr_burst_done = 0;
        rd_cmd_ready = 0; rd_burst_done = 0;
        repeat (2) tick();
        chk("rst_valid", {31'd0, rd_cmd_valid}, 32'd0);
        chk("rst_addr", rd_cmd_addr, 32'h0);
        chk("rst_avail", {21'd0, avail_bursts}, 32'd0);
        chk("rst_out", {29'd0, outstanding}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic issue, 1-cycle gap, cap at two outstanding.
        wr_n(3);
        chk("s1_avail3", {21'd0, avail_bursts}, 32'd3);
        exp_q.push_back(32'h0000); exp_q.push_back(32'h1000); exp_q.push_back(32'h2000);
        rd_cmd_ready = 1; ctrl_rd_en = 1; ddr_rd_req = 1;
        tick(); chk("s1_v1", {31'd0, rd_cmd_valid}, 32'd1);
        tick(); chk("s1_gap", {31'd0, rd_cmd_valid}, 32'd0);
        tick(); chk("s1_v2", {31'd0, rd_cmd_valid}, 32'd1);
        repeat (4) tick();
        chk("s1_stall_valid", {31'd0, rd_cmd_valid}, 32'd0);
        chk("s1_out2", {29'd0, outstanding}, 32'd2);
        chk("s1_avail1", {21'd0, avail_bursts}, 32'd1);
        pulse_rd();
        repeat (4) tick();
        chk("s1_avail0", {21'd0, avail_bursts}, 32'd0);
        chk("s1_out2b", {29'd0, outstanding}, 32'd2);
        ctrl_rd_en = 0; ddr_rd_req = 0;
        pulse_rd(); pulse_rd();
        chk("s1_drained", {29'd0, outstanding}, 32'd0);
        chk("s1_busy", {31'd0, busy}, 32'd0);

        // Ring wrap: walk the pointer to slot 1023 then issue across the end.
        do_reset();
        wr_n(1023);
        for (int i = 0; i < 1023; i++) exp_q.push_back(32'h1000 * i);
        run_drain(5000);
        chk("s2_addr1023", rd_cmd_addr, 32'h003F_F000);
        wr_n(1);
        exp_q.push_back(32'h003F_F000);
        run_drain(50);
        chk("s2_wrap", rd_cmd_addr, 32'h0000_0000);

        // Stall with ready low; enable drops after the first cycle.
        wr_n(2);
        exp_q.push_back(32'h0000);
        ctrl_rd_en = 1; ddr_rd_req = 1;
        tick(); chk("s3_valid", {31'd0, rd_cmd_valid}, 32'd1);
        ctrl_rd_en = 0; ddr_rd_req = 0;
        repeat (4) tick();
        chk("s3_hold_valid", {31'd0, rd_cmd_valid}, 32'd1);
        chk("s3_hold_addr", rd_cmd_addr, 32'h0);
        rd_cmd_ready = 1;
        tick();
        repeat (3) tick();
        chk("s3_no_reissue", {31'd0, rd_cmd_valid}, 32'd0);
        chk("s3_out1", {29'd0, outstanding}, 32'd1);
        chk("s3_avail1", {21'd0, avail_bursts}, 32'd1);
        rd_cmd_ready = 0;
        pulse_rd();

        // Coincident updates.
        wr_n(3);
        chk("s4_avail4", {21'd0, avail_bursts}, 32'd4);
        exp_q.push_back(32'h1000);
        ctrl_rd_en = 1; ddr_rd_req = 1;
        tick();
        ctrl_rd_en = 0; rd_cmd_ready = 1; wr_burst_done = 1;
        tick();
        wr_burst_done = 0; rd_cmd_ready = 0;
        chk("s4_avail_same", {21'd0, avail_bursts}, 32'd4);
        chk("s4_out1", {29'd0, outstanding}, 32'd1);
        exp_q.push_back(32'h2000);
        ctrl_rd_en = 1;
        tick();
        ctrl_rd_en = 0; rd_cmd_ready = 1; rd_burst_done = 1;
        tick();
        rd_burst_done = 0; rd_cmd_ready = 0;
        chk("s4_out_same", {29'd0, outstanding}, 32'd1);
        chk("s4_avail3", {21'd0, avail_bursts}, 32'd3);
        pulse_rd();
        ddr_rd_req = 0;

        // Error flags.
        do_reset();
        pulse_rd();
        chk("s5_err_spur", {30'd0, err}, 32'd2);
        chk("s5_out0", {29'd0, outstanding}, 32'd0);
        wr_n(1025);
        chk("s5_avail_max", {21'd0, avail_bursts}, 32'd1024);
        chk("s5_err_ovf", {30'd0, err}, 32'd3);

        // Deferred clear while a burst is in flight.
        exp_q.push_back(32'h0000);
        rd_cmd_ready = 1; ctrl_rd_en = 1; ddr_rd_req = 1;
        tick();
        ctrl_rd_en = 0;
        tick();
        rd_cmd_ready = 0;
        chk("s6_out1", {29'd0, outstanding}, 32'd1);
        chk("s6_addr1", rd_cmd_addr, 32'h1000);
        clr = 1; tick(); clr = 0;
        chk("s6_deferred_avail", {21'd0, avail_bursts}, 32'd1023);
        chk("s6_deferred_err", {30'd0, err}, 32'd3);
        pulse_rd();
        tick();
        chk("s6_clr_avail", {21'd0, avail_bursts}, 32'd0);
        chk("s6_clr_addr", rd_cmd_addr, 32'h0);
        chk("s6_clr_err", {30'd0, err}, 32'd0);
        wr_n(2);
        clr = 1; wr_burst_done = 1;
        tick();
        clr = 0; wr_burst_done = 0;
        chk("s6_clr_discard_wr", {21'd0, avail_bursts}, 32'd0);

        // Async reset in the middle of ISSUE.
        wr_n(1);
        ctrl_rd_en = 1; ddr_rd_req = 1;
        tick();
        chk("s7_valid", {31'd0, rd_cmd_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s7_async_valid", {31'd0, rd_cmd_valid}, 32'd0);
        chk("s7_async_avail", {21'd0, avail_bursts}, 32'd0);
        ctrl_rd_en = 0; ddr_rd_req = 0;
        tick();
        rst_n = 1'b1;
        tick();

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
